aes_decrypt_iterative: RTL and testbench



---
 rtl/aes_decrypt_iterative.sv | 220 ++++++++++++++++++++++
 tb/tb_aes_decrypt_iterative.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_decrypt_iterative.sv
// rtl/aes_decrypt_iterative.sv - AES-128 iterative decryption core with stored round-key file

module aes_inv_sbox (
    input  logic [7:0] in_i,
    output logic [7:0] out_o
);
    localparam logic [2047:0] TABLE = {
        128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
    };
    assign out_o = TABLE[{~in_i, 3'b000} +: 8];
endmodule

module aes_sbox (
    input  logic [7:0] in_i,
    output logic [7:0] out_o
);
    localparam logic [2047:0] TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };
    assign out_o = TABLE[{~in_i, 3'b000} +: 8];
endmodule

module aes_decrypt_iterative #(
    parameter int DATA_W    = 128,
    parameter int KEY_LEN   = 128,
    parameter int NO_ROUNDS = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              key_valid_in,
    input  logic [KEY_LEN-1:0] cipher_key,
    input  logic              data_valid_in,
    input  logic [DATA_W-1:0] cipher_text,
    output logic              key_ready,
    output logic              data_ready,
    output logic              valid_out,
    output logic [DATA_W-1:0] plain_text
);
    localparam logic [3:0] LAST_RND = 4'(NO_ROUNDS);

    typedef enum logic [1:0] {IDLE, KEY_EXP, DECRYPT} state_t;

    state_t       state_q, state_d;
    logic [127:0] rk_q [0:NO_ROUNDS];
    logic [7:0]   rcon_q;
    logic [3:0]   key_cnt_q;
    logic         key_loaded_q;
    logic [127:0] st_q;
    logic [3:0]   rnd_q;
    logic         valid_q;
    logic [127:0] plain_q;

    logic load_key, exp_step, load_data, rnd_step, final_step;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
        logic [7:0] a [4];
        logic [7:0] m9 [4];
        logic [7:0] mb [4];
        logic [7:0] md [4];
        logic [7:0] me [4];
        logic [7:0] x2, x4, x8;
        for (int j = 0; j < 4; j++) begin
            a[j]  = col[31-8*j -: 8];
            x2    = xtime(a[j]);
            x4    = xtime(x2);
            x8    = xtime(x4);
            m9[j] = x8 ^ a[j];
            mb[j] = x8 ^ x2 ^ a[j];
            md[j] = x8 ^ x4 ^ a[j];
            me[j] = x8 ^ x4 ^ x2;
        end
        return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
                m9[0] ^ me[1] ^ mb[2] ^ md[3],
                md[0] ^ m9[1] ^ me[2] ^ mb[3],
                mb[0] ^ md[1] ^ m9[2] ^ me[3]};
    endfunction

    // Key expansion: one round key per cycle from the previously written one
    logic [127:0] rk_prev, rk_next;
    logic [31:0]  rot_w, sub_w, temp_w;
    logic [7:0]   sub_b [4];

    assign rk_prev = rk_q[key_cnt_q - 4'd1];
    assign rot_w   = {rk_prev[23:0], rk_prev[31:24]};

    for (genvar j = 0; j < 4; j++) begin : g_sbox
        aes_sbox u_sbox (.in_i(rot_w[31-8*j -: 8]), .out_o(sub_b[j]));
    end

    always_comb begin
        sub_w             = {sub_b[0], sub_b[1], sub_b[2], sub_b[3]};
        temp_w            = sub_w ^ {rcon_q, 24'h000000};
        rk_next[127:96]   = rk_prev[127:96] ^ temp_w;
        rk_next[95:64]    = rk_prev[95:64]  ^ rk_next[127:96];
        rk_next[63:32]    = rk_prev[63:32]  ^ rk_next[95:64];
        rk_next[31:0]     = rk_prev[31:0]   ^ rk_next[63:32];
    end

    // Inverse round: InvShiftRows folded into the S-box input wiring
    logic [7:0]   isb_b [16];
    logic [127:0] isb, ark, imc;

    for (genvar i = 0; i < 16; i++) begin : g_inv_sbox
        localparam int SRC = 4 * (((i / 4) - (i % 4) + 4) % 4) + (i % 4);
        aes_inv_sbox u_inv_sbox (.in_i(st_q[127-8*SRC -: 8]), .out_o(isb_b[i]));
    end

    always_comb begin
        isb = '0;
        for (int i = 0; i < 16; i++) begin
            isb[127-8*i -: 8] = isb_b[i];
        end
        ark = isb ^ rk_q[rnd_q];
        imc = '0;
        for (int c = 0; c < 4; c++) begin
            imc[127-32*c -: 32] = inv_mix_col(ark[127-32*c -: 32]);
        end
    end

    always_comb begin
        state_d    = state_q;
        load_key   = 1'b0;
        exp_step   = 1'b0;
        load_data  = 1'b0;
        rnd_step   = 1'b0;
        final_step = 1'b0;
        case (state_q)
            IDLE: begin
                if (key_valid_in) begin
                    load_key = 1'b1;
                    state_d  = KEY_EXP;
                end else if (data_valid_in && key_loaded_q) begin
                    load_data = 1'b1;
                    state_d   = DECRYPT;
                end
            end
            KEY_EXP: begin
                exp_step = 1'b1;
                if (key_cnt_q == LAST_RND) state_d = IDLE;
            end
            DECRYPT: begin
                if (rnd_q == 4'd0) begin
                    final_step = 1'b1;
                    state_d    = IDLE;
                end else begin
                    rnd_step = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k <= NO_ROUNDS; k++) rk_q[k] <= '0;
            rcon_q       <= 8'h00;
            key_cnt_q    <= 4'd0;
            key_loaded_q <= 1'b0;
            st_q         <= '0;
            rnd_q        <= 4'd0;
            valid_q      <= 1'b0;
            plain_q      <= '0;
        end else begin
            valid_q <= final_step;
            if (load_key) begin
                rk_q[0]      <= cipher_key;
                rcon_q       <= 8'h01;
                key_cnt_q    <= 4'd1;
                key_loaded_q <= 1'b0;
            end
            if (exp_step) begin
                rk_q[key_cnt_q] <= rk_next;
                rcon_q          <= xtime(rcon_q);
                key_cnt_q       <= key_cnt_q + 4'd1;
                if (key_cnt_q == LAST_RND) key_loaded_q <= 1'b1;
            end
            if (load_data) begin
                st_q  <= cipher_text ^ rk_q[LAST_RND];
                rnd_q <= LAST_RND - 4'd1;
            end
            if (rnd_step) begin
                st_q  <= imc;
                rnd_q <= rnd_q - 4'd1;
            end
            if (final_step) plain_q <= ark;
        end
    end

    assign key_ready  = (state_q == IDLE);
    assign data_ready = (state_q == IDLE) && key_loaded_q;
    assign valid_out  = valid_q;
    assign plain_text = plain_q;

endmodule

// File: tb/tb_aes_decrypt_iterative.sv
// tb/tb_aes_decrypt_iterative.sv - directed and loopback checks for aes_decrypt_iterative

module tb_aes_decrypt_iterative;
    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         key_valid_in = 1'b0;
    logic [127:0] cipher_key = '0;
    logic         data_valid_in = 1'b0;
    logic [127:0] cipher_text = '0;
    logic         key_ready, data_ready, valid_out;
    logic [127:0] plain_text;

    int tests = 0;
    int fails = 0;
    int cycle_no = 0;

    aes_decrypt_iterative dut (
        .clk(clk), .reset(reset),
        .key_valid_in(key_valid_in), .cipher_key(cipher_key),
        .data_valid_in(data_valid_in), .cipher_text(cipher_text),
        .key_ready(key_ready), .data_ready(data_ready),
        .valid_out(valid_out), .plain_text(plain_text)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cycle_no <= cycle_no + 1;

    localparam logic [2047:0] SBOX_T = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sb(input logic [7:0] x);
        logic [2047:0] t;
        t = SBOX_T;
        return t[{~x, 3'b000} +: 8];
    endfunction

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Forward AES-128 reference used to produce loopback ciphertexts
    function automatic logic [127:0] aes_enc(input logic [127:0] key, input logic [127:0] pt);
        logic [127:0] rk, s, t, m;
        logic [31:0]  w;
        logic [7:0]   rc, a0, a1, a2, a3;
        int           c, rr, src;
        rk = key;
        s  = pt ^ key;
        rc = 8'h01;
        for (int r = 1; r <= 10; r++) begin
            w = rk[31:0];
            w = {sb(w[23:16]), sb(w[15:8]), sb(w[7:0]), sb(w[31:24])} ^ {rc, 24'h000000};
            rk[127:96] = rk[127:96] ^ w;
            rk[95:64]  = rk[95:64] ^ rk[127:96];
            rk[63:32]  = rk[63:32] ^ rk[95:64];
            rk[31:0]   = rk[31:0] ^ rk[63:32];
            rc = xt(rc);
            for (int i = 0; i < 16; i++) begin
                c   = i / 4;
                rr  = i % 4;
                src = 4 * ((c + rr) % 4) + rr;
                t[127-8*i -: 8] = sb(s[127-8*src -: 8]);
            end
            m = t;
            if (r != 10) begin
                for (int k = 0; k < 4; k++) begin
                    a0 = t[127-32*k -: 8];
                    a1 = t[119-32*k -: 8];
                    a2 = t[111-32*k -: 8];
                    a3 = t[103-32*k -: 8];
                    m[127-32*k -: 8] = xt(a0) ^ (xt(a1) ^ a1) ^ a2 ^ a3;
                    m[119-32*k -: 8] = a0 ^ xt(a1) ^ (xt(a2) ^ a2) ^ a3;
                    m[111-32*k -: 8] = a0 ^ a1 ^ xt(a2) ^ (xt(a3) ^ a3);
                    m[103-32*k -: 8] = (xt(a0) ^ a0) ^ a1 ^ a2 ^ xt(a3);
                end
            end
            s = m ^ rk;
        end
        return s;
    endfunction

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic load_key(input logic [127:0] k);
        key_valid_in = 1'b1;
        cipher_key   = k;
        @(posedge clk); #1;
        key_valid_in = 1'b0;
    endtask

    task automatic send_block(input logic [127:0] ct);
        data_valid_in = 1'b1;
        cipher_text   = ct;
        @(posedge clk); #1;
        data_valid_in = 1'b0;
    endtask

    task automatic wait_ready(output int cyc, output int nv);
        cyc = 0;
        nv  = 0;
        while (!data_ready && cyc < 30) begin
            @(posedge clk); #1;
            cyc++;
            if (valid_out) nv++;
        end
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (!valid_out && lat < 30) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic count_valid(input int n, output int nv);
        nv = 0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            if (valid_out) nv++;
        end
    endtask

    typedef struct {
        string        name;
        logic [127:0] key;
        logic [127:0] ct;
        logic [127:0] pt;
        logic [127:0] rk10;
    } vec_t;

    vec_t vecs [2];

    localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C1_RK  = 128'h13111d7fe3944a17f307a78b4d2b30c5;
    localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;

    initial begin
        int cyc, nv, lat, t1, t2, lb_err;
        logic [127:0] pt2, ct2, k, p;

        vecs[0] = '{"c1", C1_KEY, C1_CT, C1_PT, C1_RK};
        vecs[1] = '{"appb", B_KEY, 128'h3925841d02dc09fbdc118597196a0b32,
                    128'h3243f6a8885a308d313198a2e0370734, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6};

        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        check("rst_valid_out", 128'(valid_out), 128'd0);
        check("rst_plain_text", plain_text, 128'd0);
        check("rst_key_ready", 128'(key_ready), 128'd1);
        check("rst_data_ready", 128'(data_ready), 128'd0);

        // Data before any key is dropped
        send_block(C1_CT);
        count_valid(15, nv);
        check("nokey_no_output", 128'(nv), 128'd0);

        // Key and data together: key wins; key strobe during KEY_EXP is dropped
        key_valid_in  = 1'b1;
        cipher_key    = C1_KEY;
        data_valid_in = 1'b1;
        cipher_text   = C1_CT;
        @(posedge clk); #1;
        key_valid_in  = 1'b0;
        data_valid_in = 1'b0;
        check("kexp_key_ready_low", 128'(key_ready), 128'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        key_valid_in  = 1'b1;
        cipher_key    = B_KEY;
        @(posedge clk); #1;
        key_valid_in  = 1'b0;
        wait_ready(cyc, nv);
        check("both_strobe_no_output", 128'(nv), 128'd0);
        check("both_strobe_rk10", dut.rk_q[10], C1_RK);
        count_valid(5, nv);
        check("both_strobe_idle_quiet", 128'(nv), 128'd0);

        for (int v = 0; v < 2; v++) begin
            load_key(vecs[v].key);
            wait_ready(cyc, nv);
            check({vecs[v].name, "_keyload_cycles"}, 128'(cyc), 128'd10);
            check({vecs[v].name, "_rk10"}, dut.rk_q[10], vecs[v].rk10);
            send_block(vecs[v].ct);
            wait_valid(lat);
            check({vecs[v].name, "_latency"}, 128'(lat), 128'd10);
            check({vecs[v].name, "_plain_text"}, plain_text, vecs[v].pt);
            @(posedge clk); #1;
            check({vecs[v].name, "_valid_width"}, 128'(valid_out), 128'd0);
            check({vecs[v].name, "_plain_hold"}, plain_text, vecs[v].pt);
        end

        // Data refused while a new key is expanding
        load_key(C1_KEY);
        @(posedge clk); #1;
        send_block(C1_CT);
        wait_ready(cyc, nv);
        count_valid(15, nv);
        check("rekey_data_refused", 128'(nv), 128'd0);

        // Back-to-back blocks, plus a dropped mid-DECRYPT strobe
        pt2 = 128'hdeadbeef0123456789abcdeffedcba98;
        ct2 = aes_enc(C1_KEY, pt2);
        send_block(C1_CT);
        wait_valid(lat);
        t1 = cycle_no;
        check("b2b_first_pt", plain_text, C1_PT);
        check("b2b_data_ready_in_valid", 128'(data_ready), 128'd1);
        send_block(ct2);
        repeat (4) begin @(posedge clk); #1; end
        send_block(C1_CT);
        wait_valid(lat);
        t2 = cycle_no;
        check("b2b_spacing", 128'(t2 - t1), 128'd11);
        check("b2b_second_pt", plain_text, pt2);
        count_valid(20, nv);
        check("mid_decrypt_strobe_dropped", 128'(nv), 128'd0);

        // Reset during round 5
        send_block(C1_CT);
        repeat (4) begin @(posedge clk); #1; end
        reset = 1'b1;
        #1;
        check("midrst_valid_out", 128'(valid_out), 128'd0);
        check("midrst_plain_text", plain_text, 128'd0);
        check("midrst_key_ready", 128'(key_ready), 128'd1);
        check("midrst_data_ready", 128'(data_ready), 128'd0);
        check("midrst_rk10", dut.rk_q[10], 128'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        send_block(C1_CT);
        count_valid(15, nv);
        check("midrst_no_output", 128'(nv), 128'd0);
        load_key(C1_KEY);
        wait_ready(cyc, nv);
        send_block(C1_CT);
        wait_valid(lat);
        check("midrst_reload_latency", 128'(lat), 128'd10);
        check("midrst_reload_pt", plain_text, C1_PT);

        // Loopback against the forward reference
        lb_err = 0;
        for (int n = 0; n < 1000; n++) begin
            k = {$urandom, $urandom, $urandom, $urandom};
            p = {$urandom, $urandom, $urandom, $urandom};
            load_key(k);
            wait_ready(cyc, nv);
            send_block(aes_enc(k, p));
            wait_valid(lat);
            if (!valid_out || plain_text !== p) lb_err++;
        end
        check("loopback_errors", 128'(lb_err), 128'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
